// File: rtl/alu_1.sv
// -----------------------------------------------------------------------------
// alu_1 -- branch-target address adder for the 16-bit RISC datapath.
//
// Adds the incremented program counter to the sign-extended branch offset.
// The sum and its carry/overflow flags are produced combinationally for the
// next-PC select mux. A one-stage registered copy, qualified by in_valid, is
// provided for the pipeline and hazard logic.
//
// Optional feature (compile-time macro ALU_1_OVF_TRAP_EN):
//   adds a sticky signed-overflow trap (ovf_sticky) with a synchronous
//   clear (ovf_clr). When the macro is undefined neither port exists.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   PC_plus_one     in   [N]  incremented PC (unsigned)
//   Sign_ext_1_out  in   [N]  sign-extended branch offset (two's complement)
//   in_valid        in   qualifies operands for the registered stage
//   ovf_clr         in   synchronous clear of ovf_sticky (trap build only)
//   ALU_1_out       out  [N]  combinational sum, modulo 2^N
//   carry_out       out  combinational carry out of bit N-1
//   overflow        out  combinational signed overflow
//   out_valid       out  registered in_valid
//   ALU_1_out_q     out  [N]  registered sum
//   carry_q         out  registered carry
//   overflow_q      out  registered overflow
//   zero_q          out  registered "sum == 0"
//   ovf_sticky      out  sticky overflow trap (trap build only)
// -----------------------------------------------------------------------------
module alu_1 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] PC_plus_one,
    input  logic [N-1:0] Sign_ext_1_out,
    input  logic         in_valid,
`ifdef ALU_1_OVF_TRAP_EN
    input  logic         ovf_clr,
    output logic         ovf_sticky,
`endif
    output logic [N-1:0] ALU_1_out,
    output logic         carry_out,
    output logic         overflow,
    output logic         out_valid,
    output logic [N-1:0] ALU_1_out_q,
    output logic         carry_q,
    output logic         overflow_q,
    output logic         zero_q
);

    // One extra bit captures the unsigned carry out of the top bit.
    logic [N:0] sum_ext;
    logic       sum_zero;

    // Purely combinational: no dependence on clk, rst_n or in_valid, so the
    // branch target settles as soon as the operands do.
    always_comb begin
        sum_ext   = {1'b0, PC_plus_one} + {1'b0, Sign_ext_1_out};
        ALU_1_out = sum_ext[N-1:0];
        carry_out = sum_ext[N];
        // Signed overflow: operands agree in sign but the result does not.
        overflow  = (PC_plus_one[N-1] == Sign_ext_1_out[N-1]) &&
                    (sum_ext[N-1] != PC_plus_one[N-1]);
        sum_zero  = (sum_ext[N-1:0] == '0);
    end

    // out_valid follows in_valid every cycle; reset clears it immediately so
    // a result in flight is dropped.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result registers load only on a qualified cycle and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_1_out_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (in_valid) begin
            ALU_1_out_q <= ALU_1_out;
            carry_q     <= carry_out;
            overflow_q  <= overflow;
            zero_q      <= sum_zero;
        end
    end

`ifdef ALU_1_OVF_TRAP_EN
    // Sticky trap: a qualified overflow sets it, ovf_clr clears it. The set
    // term is tested first so a new overflow is never lost to a clear
    // arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (in_valid && overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_1.sv
// -----------------------------------------------------------------------------
// tb_alu_1 -- self-checking bench for alu_1.
//
// Combinational results are compared directly against hand-computed values.
// Registered results go through a scoreboard: each qualified vector pushes
// its expected registered response, and a monitor pops and compares whenever
// the DUT presents out_valid. Build with +define+ALU_1_OVF_TRAP_EN to also
// exercise the sticky overflow trap.
// -----------------------------------------------------------------------------
module tb_alu_1;

    localparam int N = 16;

    typedef struct {
        logic [N-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic [N-1:0] PC_plus_one;
    logic [N-1:0] Sign_ext_1_out;
    logic         in_valid;
    logic [N-1:0] ALU_1_out;
    logic         carry_out;
    logic         overflow;
    logic         out_valid;
    logic [N-1:0] ALU_1_out_q;
    logic         carry_q;
    logic         overflow_q;
    logic         zero_q;
`ifdef ALU_1_OVF_TRAP_EN
    logic         ovf_clr;
    logic         ovf_sticky;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_1 #(.N(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_plus_one    (PC_plus_one),
        .Sign_ext_1_out (Sign_ext_1_out),
        .in_valid       (in_valid),
`ifdef ALU_1_OVF_TRAP_EN
        .ovf_clr        (ovf_clr),
        .ovf_sticky     (ovf_sticky),
`endif
        .ALU_1_out      (ALU_1_out),
        .carry_out      (carry_out),
        .overflow       (overflow),
        .out_valid      (out_valid),
        .ALU_1_out_q    (ALU_1_out_q),
        .carry_q        (carry_q),
        .overflow_q     (overflow_q),
        .zero_q         (zero_q)
    );

    // Clock is held low until clk_en is set, so the early combinational
    // checks run with no clock activity at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic check_comb(input string name, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [N-1:0] sum,
                              input logic c, input logic o);
        PC_plus_one    = a;
        Sign_ext_1_out = b;
        #1;
        check({name, "_sum"}, 32'(ALU_1_out), 32'(sum));
        check({name, "_carry"}, 32'(carry_out), 32'(c));
        check({name, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    // Called at a negedge: drive a qualified vector, record its expected
    // registered response, and advance to the next negedge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] sum, input logic c,
                         input logic o, input logic z);
        exp_t e;
        PC_plus_one    = a;
        Sign_ext_1_out = b;
        in_valid       = 1'b1;
        e.sum   = sum;
        e.carry = c;
        e.ovf   = o;
        e.zero  = z;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare registered outputs whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: out_valid=1 with no expected entry (t=%0t)",
                             $time);
                end else begin
                    e = sb.pop_front();
                    check("q_sum", 32'(ALU_1_out_q), 32'(e.sum));
                    check("q_carry", 32'(carry_q), 32'(e.carry));
                    check("q_ovf", 32'(overflow_q), 32'(e.ovf));
                    check("q_zero", 32'(zero_q), 32'(e.zero));
                end
            end
        end
    end

    initial begin
        clk_en         = 1'b0;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        PC_plus_one    = '0;
        Sign_ext_1_out = '0;
`ifdef ALU_1_OVF_TRAP_EN
        ovf_clr        = 1'b0;
`endif
        #2;
        // Reset state, reached asynchronously with no clock edges.
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sum_q", 32'(ALU_1_out_q), 32'h0);
        check("rst_carry_q", 32'(carry_q), 32'h0);
        check("rst_ovf_q", 32'(overflow_q), 32'h0);
        check("rst_zero_q", 32'(zero_q), 32'h0);
`ifdef ALU_1_OVF_TRAP_EN
        check("rst_sticky", 32'(ovf_sticky), 32'h0);
`endif
        rst_n = 1'b1;
        #2;

        // Combinational path with the clock stopped.
        check_comb("c_0_20",    16'd0,     16'd20,    16'd20,    1'b0, 1'b0);
        check_comb("c_10_20",   16'd10,    16'd20,    16'd30,    1'b0, 1'b0);
        check_comb("c_10_0",    16'd10,    16'd0,     16'd10,    1'b0, 1'b0);
        check_comb("c_neg4",    16'h0010,  16'hFFFC,  16'h000C,  1'b1, 1'b0);
        check_comb("c_wrap",    16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0);
        check_comb("c_sovf",    16'h7FFF,  16'h0001,  16'h8000,  1'b0, 1'b1);
        check_comb("c_minus1",  16'h0000,  16'hFFFF,  16'hFFFF,  1'b0, 1'b0);
        check_comb("c_negovf",  16'h8000,  16'h8000,  16'h0000,  1'b1, 1'b1);

        // The registered stage must not have moved without a clock.
        check("noclk_out_valid", 32'(out_valid), 32'h0);
        check("noclk_sum_q", 32'(ALU_1_out_q), 32'h0);

        clk_en = 1'b1;
        @(negedge clk);

        // Wrap to zero, then drop in_valid and confirm the hold.
        issue(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        in_valid       = 1'b0;
        PC_plus_one    = 16'h1234;
        Sign_ext_1_out = 16'h1111;
        @(negedge clk);
        check("hold1_out_valid", 32'(out_valid), 32'h0);
        check("hold1_sum_q", 32'(ALU_1_out_q), 32'h0000);
        check("hold1_carry_q", 32'(carry_q), 32'h1);
        check("hold1_zero_q", 32'(zero_q), 32'h1);
        check("hold1_comb_sum", 32'(ALU_1_out), 32'h2345);

        // Signed overflow, then hold with new operands.
        issue(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        in_valid       = 1'b0;
        PC_plus_one    = 16'h0001;
        Sign_ext_1_out = 16'h0001;
        @(negedge clk);
        check("hold2_ovf_q", 32'(overflow_q), 32'h1);
        check("hold2_sum_q", 32'(ALU_1_out_q), 32'h8000);
`ifdef ALU_1_OVF_TRAP_EN
        check("sticky_persist", 32'(ovf_sticky), 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("sticky_cleared", 32'(ovf_sticky), 32'h0);
        @(negedge clk);
        check("sticky_stays_clr", 32'(ovf_sticky), 32'h0);
        // Set and clear together: the set must win.
        ovf_clr = 1'b1;
        issue(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        ovf_clr = 1'b0;
        check("sticky_set_wins", 32'(ovf_sticky), 32'h1);
`endif

        // Back-to-back qualified vectors.
        issue(16'h0010, 16'hFFFC, 16'h000C, 1'b1, 1'b0, 1'b0);
        issue(16'h0100, 16'h0023, 16'h0123, 1'b0, 1'b0, 1'b0);

        // Launch a vector, then reset before its capture edge.
        PC_plus_one    = 16'h8000;
        Sign_ext_1_out = 16'h8000;
        in_valid       = 1'b1;
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_sum_q", 32'(ALU_1_out_q), 32'h0);
        check("arst_carry_q", 32'(carry_q), 32'h0);
        check("arst_ovf_q", 32'(overflow_q), 32'h0);
        check("arst_zero_q", 32'(zero_q), 32'h0);
`ifdef ALU_1_OVF_TRAP_EN
        check("arst_sticky", 32'(ovf_sticky), 32'h0);
`endif
        // Combinational path keeps working during reset.
        check("arst_comb_sum", 32'(ALU_1_out), 32'h0000);
        check("arst_comb_carry", 32'(carry_out), 32'h1);
        check("arst_comb_ovf", 32'(overflow), 32'h1);
        check_comb("arst_track", 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
        check("post_rst_sum_q", 32'(ALU_1_out_q), 32'h0);

        // One final qualified vector after reset, then drain.
        issue(16'h0100, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_1.md
Name: alu_1

Overview:
- Branch-target address adder for the 16-bit RISC CPU datapath.
- Adds the incremented PC (PC_plus_one) to the sign-extended branch offset (Sign_ext_1_out).
- Presents the sum combinationally to the PC-select mux, plus a one-stage registered copy with status flags for the pipeline/hazard logic.
- Sits between the PC incrementer/sign-extender and the next-PC mux.

Parameters:
- N, 16, datapath width in bits for addresses, offset and result.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- PC_plus_one  input  N  incremented program counter (unsigned address).
- Sign_ext_1_out  input  N  sign-extended branch offset (two's complement).
- in_valid  input  1  qualifies the inputs for the registered stage.
- ALU_1_out  output  N  combinational sum, PC_plus_one + Sign_ext_1_out, modulo 2^N.
- carry_out  output  1  combinational carry out of bit N-1.
- overflow  output  1  combinational signed overflow of the addition.
- out_valid  output  1  registered in_valid.
- ALU_1_out_q  output  N  registered ALU_1_out.
- carry_q  output  1  registered carry_out.
- overflow_q  output  1  registered overflow.
- zero_q  output  1  registered flag: sum equals 0.
- ovf_sticky  output  1  sticky overflow trap; exists only with the optional feature.
- ovf_clr  input  1  synchronous clear of ovf_sticky; exists only with the optional feature.

Behaviour:
- Combinational path, zero latency:
  - ALU_1_out = (PC_plus_one + Sign_ext_1_out) mod 2^N. Wrap-around is silent.
  - The combinational path is independent of clk, rst_n and in_valid. It must settle with no clock toggling.
- carry_out: bit N of the (N+1)-bit unsigned sum.
- overflow: asserted when both operands share the same MSB and the sum's MSB differs from it.
- Registered stage, 1-cycle latency:
  - out_valid <= in_valid on every cycle.
  - When in_valid = 1: ALU_1_out_q, carry_q, overflow_q and zero_q load from the combinational values.
  - When in_valid = 0: those four registers hold their previous values.
- Reset (async assert, sync-safe deassert):
  - All registered outputs go to 0: out_valid, ALU_1_out_q, carry_q, overflow_q, zero_q, and ovf_sticky if present.
  - Reset mid-operation discards the pending result immediately.
- Inputs containing X/Z propagate X on the combinational outputs. No special handling is required.
- Boundary conditions:
  - 0xFFFF + 0x0001 gives 0x0000, carry 1, overflow 0.
  - 0x7FFF + 0x0001 gives 0x8000, carry 0, overflow 1.
  - 0x0000 + 0xFFFF (offset -1) gives 0xFFFF, carry 0, overflow 0.

Optional Feature:
- Macro: ALU_1_OVF_TRAP_EN.
- Defined:
  - ovf_sticky and ovf_clr exist.
  - ovf_sticky sets to 1 on any clock edge where in_valid = 1 and overflow = 1.
  - It stays set until ovf_clr = 1 on a clock edge, or until reset.
  - Set and clear in the same cycle: set wins.
- Not defined:
  - Neither port exists. All other behaviour is identical.

Test Plan:
- PC_plus_one=0, Sign_ext_1_out=20 -> ALU_1_out=20 immediately, no clock. Then PC_plus_one=10 -> 30. Then Sign_ext_1_out=0 -> 10.
- PC_plus_one=0x0010, Sign_ext_1_out=0xFFFC (-4) -> ALU_1_out=0x000C, carry_out=1, overflow=0.
- 0xFFFF+0x0001 with in_valid=1, one clock -> ALU_1_out_q=0, zero_q=1, carry_q=1, out_valid=1. Drop in_valid, change inputs -> _q outputs hold, out_valid=0 next cycle.
- 0x7FFF+0x0001 -> overflow=1, ALU_1_out=0x8000. Registered -> overflow_q=1. With ALU_1_OVF_TRAP_EN: ovf_sticky=1 persists after inputs change; ovf_clr pulse -> 0.
- Assert rst_n=0 between clock edges with registered outputs nonzero -> all registered outputs 0 without waiting for clk. Combinational ALU_1_out still tracks inputs during reset.
